// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_BUSY    = 2'd2
    } state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    // addi x0, x0, 0 -- what a bubble becomes once it reaches the pipeline registers
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic use1, input logic use2,
                                      input logic [4:0] rd, input logic memread);
        return memread && (rd != REG_ZERO) &&
               ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_watchdog.sv
// Multi-cycle unit watchdog: down-counter of remaining MC_BUSY cycles with a
// terminal-count flag and a registered one-cycle error pulse.
module hazard_watchdog #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    input  logic fire_i,
    output logic tc_o,
    output logic err_o
);
    localparam int unsigned WD_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MC_TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = WD_LOAD;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= fire_i;
        end
    end

    assign tc_o  = (cnt_q == '0);
    assign err_o = err_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/bubble/flush sequencing for the 5-stage pipeline.
// Performance counters are built only when HAZ_PERF_CNT_EN is defined.
//
// state      | meaning
// RUN        | normal issue; branch, multi-cycle start and load-use resolved here
// LOAD_STALL | extra load-use bubbles beyond the first (LOAD_LAT=2)
// MC_BUSY    | EX held waiting on mc_done, watchdog running
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_mc_start_i,
    input  logic             mc_done_i,
    input  logic             ex_branch_taken_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_hold_o,
    output logic             ex_mem_bubble_o,
    output logic             mc_timeout_err_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);
    state_e     state_q, state_d;
    logic [1:0] lcnt_q, lcnt_d;
    logic       lu, wd_load, wd_dec, wd_fire, wd_tc;

    assign lu = load_use(id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_memread_i);

    assign wd_load = (state_q == RUN) && !ex_branch_taken_i && ex_mc_start_i && !mc_done_i;
    assign wd_dec  = (state_q == MC_BUSY) && !mc_done_i;
    assign wd_fire = wd_dec && wd_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            lcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        unique case (state_q)
            RUN: begin
                if (ex_branch_taken_i) begin
                    state_d = RUN;
                end else if (ex_mc_start_i && !mc_done_i) begin
                    state_d = MC_BUSY;
                end else if (ex_mc_start_i) begin
                    state_d = RUN;
                end else if (lu && (LOAD_LAT > 1)) begin
                    state_d = LOAD_STALL;
                    lcnt_d  = 2'(LOAD_LAT - 1);
                end
            end
            LOAD_STALL: begin
                lcnt_d = lcnt_q - 1'b1;
                if (lcnt_q == 2'd1) state_d = RUN;
            end
            MC_BUSY: begin
                if (mc_done_i || wd_tc) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_hold_o       = 1'b0;
        ex_mem_bubble_o = 1'b0;
        if (!rst_n) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken_i) begin
                        if_id_flush_o  = 1'b1;
                        id_ex_bubble_o = 1'b1;
                    end else if (ex_mc_start_i && !mc_done_i) begin
                        pc_write_o      = 1'b0;
                        if_id_write_o   = 1'b0;
                        ex_hold_o       = 1'b1;
                        ex_mem_bubble_o = 1'b1;
                    end else if (!ex_mc_start_i && lu) begin
                        pc_write_o     = 1'b0;
                        if_id_write_o  = 1'b0;
                        id_ex_bubble_o = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    pc_write_o     = 1'b0;
                    if_id_write_o  = 1'b0;
                    id_ex_bubble_o = 1'b1;
                end
                MC_BUSY: begin
                    if (wd_fire) begin
                        ex_mem_bubble_o = 1'b1;
                    end else if (!mc_done_i) begin
                        pc_write_o      = 1'b0;
                        if_id_write_o   = 1'b0;
                        ex_hold_o       = 1'b1;
                        ex_mem_bubble_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    hazard_watchdog #(.MC_TIMEOUT(MC_TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (wd_load),
        .dec_i  (wd_dec),
        .fire_i (wd_fire),
        .tc_o   (wd_tc),
        .err_o  (mc_timeout_err_o)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             flush_evt;

    assign flush_evt = (state_q == RUN) && ex_branch_taken_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_o && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
            if (flush_evt && (flush_q != {CNT_W{1'b1}}))   flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_events_o = flush_q;
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit: one instance with LOAD_LAT=1,
// one with LOAD_LAT=2 and narrow counters, both MC_TIMEOUT=8, sharing inputs.
module tb_hazard_control_unit;

    localparam int CW_B = 3;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // control vector bits: pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, mc_timeout_err
    localparam logic [6:0] C_RST = 7'b0011000;
    localparam logic [6:0] C_DEF = 7'b1100000;
    localparam logic [6:0] C_LU  = 7'b0001000;
    localparam logic [6:0] C_BR  = 7'b1111000;
    localparam logic [6:0] C_MC  = 7'b0000110;
    localparam logic [6:0] C_TO  = 7'b1100010;
    localparam logic [6:0] C_ERR = 7'b1100001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_mc_start, mc_done, ex_branch_taken;

    logic a_pc, a_ifid, a_fl, a_bub, a_hold, a_exm, a_err;
    logic b_pc, b_ifid, b_fl, b_bub, b_hold, b_exm, b_err;
    logic [15:0]     a_stall, a_flush;
    logic [CW_B-1:0] b_stall, b_flush;

    hazard_control_unit #(.LOAD_LAT(1), .MC_TIMEOUT(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rd_i(ex_rd), .ex_memread_i(ex_memread), .ex_mc_start_i(ex_mc_start), .mc_done_i(mc_done),
        .ex_branch_taken_i(ex_branch_taken),
        .pc_write_o(a_pc), .if_id_write_o(a_ifid), .if_id_flush_o(a_fl), .id_ex_bubble_o(a_bub),
        .ex_hold_o(a_hold), .ex_mem_bubble_o(a_exm), .mc_timeout_err_o(a_err),
        .stall_cycles_o(a_stall), .flush_events_o(a_flush)
    );

    hazard_control_unit #(.LOAD_LAT(2), .MC_TIMEOUT(8), .CNT_W(CW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rd_i(ex_rd), .ex_memread_i(ex_memread), .ex_mc_start_i(ex_mc_start), .mc_done_i(mc_done),
        .ex_branch_taken_i(ex_branch_taken),
        .pc_write_o(b_pc), .if_id_write_o(b_ifid), .if_id_flush_o(b_fl), .id_ex_bubble_o(b_bub),
        .ex_hold_o(b_hold), .ex_mem_bubble_o(b_exm), .mc_timeout_err_o(b_err),
        .stall_cycles_o(b_stall), .flush_events_o(b_flush)
    );

    typedef struct packed {
        logic [6:0]      ctl_a;
        logic [6:0]      ctl_b;
        logic            chk_b;
        logic [15:0]     st_a;
        logic [15:0]     fl_a;
        logic [CW_B-1:0] st_b;
        logic [CW_B-1:0] fl_b;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int m_st_a = 0, m_fl_a = 0, m_st_b = 0, m_fl_b = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int sat(input int v, input int w);
        return (v >= (1 << w) - 1) ? (1 << w) - 1 : v + 1;
    endfunction

    task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] rd,
                        input bit mr, input bit mcs, input bit done, input bit br,
                        input logic [6:0] ea, input logic [6:0] eb, input bit cb, input string tag);
        exp_t  e;
        string t;
        rst_n = rst;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_memread = mr; ex_mc_start = mcs; mc_done = done; ex_branch_taken = br;
        e.ctl_a = ea;
        e.ctl_b = eb;
        e.chk_b = cb;
        e.st_a  = (PERF && rst) ? 16'(m_st_a) : 16'd0;
        e.fl_a  = (PERF && rst) ? 16'(m_fl_a) : 16'd0;
        e.st_b  = (PERF && rst) ? CW_B'(m_st_b) : '0;
        e.fl_b  = (PERF && rst) ? CW_B'(m_fl_b) : '0;
        sb_q.push_back(e);
        tag_q.push_back(tag);

        @(negedge clk);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".ctl_a"}, {9'd0, a_pc, a_ifid, a_fl, a_bub, a_hold, a_exm, a_err}, {9'd0, e.ctl_a});
        check({t, ".stall_a"}, a_stall, e.st_a);
        check({t, ".flush_a"}, a_flush, e.fl_a);
        if (e.chk_b) begin
            check({t, ".ctl_b"}, {9'd0, b_pc, b_ifid, b_fl, b_bub, b_hold, b_exm, b_err}, {9'd0, e.ctl_b});
            check({t, ".stall_b"}, {13'd0, b_stall}, {13'd0, e.st_b});
            check({t, ".flush_b"}, {13'd0, b_flush}, {13'd0, e.fl_b});
        end

        if (rst) begin
            if (!ea[6]) m_st_a = sat(m_st_a, 16);
            if (ea[4])  m_fl_a = sat(m_fl_a, 16);
            if (!eb[6]) m_st_b = sat(m_st_b, CW_B);
            if (eb[4])  m_fl_b = sat(m_fl_b, CW_B);
        end else begin
            m_st_a = 0; m_fl_a = 0; m_st_b = 0; m_fl_b = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_memread = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0; ex_branch_taken = 1'b0;

        // instance A: LOAD_LAT=1 behaviour
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, C_RST, 1, "reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, C_RST, 1, "reset_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 1, "idle");
        step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, C_LU,  C_DEF, 0, "lu_rs1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 0, "after_lu");
        step(1, 0, 7, 0, 1, 7, 1, 0, 0, 0, C_LU,  C_DEF, 0, "lu_rs2");
        step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, C_DEF, C_DEF, 0, "lu_x0");
        step(1, 5, 0, 0, 0, 5, 1, 0, 0, 0, C_DEF, C_DEF, 0, "lu_nouse");
        step(1, 5, 0, 1, 0, 5, 1, 0, 0, 1, C_BR,  C_DEF, 0, "br_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 0, "after_br");

        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MC,  C_DEF, 0, "mc_start");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MC,  C_DEF, 0, "mc_busy1");
        step(1, 5, 0, 1, 0, 5, 1, 1, 0, 1, C_MC,  C_DEF, 0, "mc_busy_ign");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MC,  C_DEF, 0, "mc_busy3");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_DEF, C_DEF, 0, "mc_done");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 0, "after_mc");
        step(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, C_DEF, C_DEF, 0, "mc_fast_lu");

        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MC, C_DEF, 0, "wd_stall");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_TO,  C_DEF, 0, "wd_fire");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ERR, C_DEF, 0, "wd_err");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 0, "wd_err_clr");

        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MC, C_DEF, 0, "wd_prio_stall");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_DEF, C_DEF, 0, "wd_done_prio");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 0, "wd_no_err");

        // both instances from a common reset; B has LOAD_LAT=2 and 3-bit counters
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, C_RST, 1, "rst2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 1, "idle2");
        step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, C_LU,  C_LU,  1, "lu2_first");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_BR,  C_LU,  1, "lu2_stall_br");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 1, "lu2_done");
        for (int i = 0; i < 4; i++) begin
            step(1, 9, 0, 1, 0, 9, 1, 0, 0, 0, C_LU,  C_LU, 1, "sat_lu");
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_LU, 1, "sat_stall");
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 1, "sat_check");

        step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, C_LU,  C_LU,  1, "lu2_pre_rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, C_RST, 1, "rst_in_stall");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 1, "post_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, C_DEF, 1, "post_rst2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
